// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Types, constants and helpers shared by the hazard scoreboard and its
//   per-entry comparator.
//
//   sb_entry_t   : one in-flight instruction {dst, we, tnew}
//   FWD_*        : forwarding select codes driven onto the operand muxes
//   TUSE_*       : stage distance at which a source operand is consumed
//   tnew_dec     : Tnew decrement applied as an entry advances one stage
//   entry_hits   : "entry will write register r" test; $0 never matches
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

    // Register address width carried in an entry. The top-level REG_AW
    // parameter must equal this value.
    localparam int SB_REG_AW = 5;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [1:0] TUSE_ID  = 2'd0;
    localparam logic [1:0] TUSE_EX  = 2'd1;
    localparam logic [1:0] TUSE_MEM = 2'd2;

    typedef struct packed {
        logic [SB_REG_AW-1:0] dst;
        logic                 we;
        logic [1:0]           tnew;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    // Tnew counts down by one per stage and saturates at zero.
    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    function automatic logic entry_hits(input sb_entry_t            e,
                                        input logic [SB_REG_AW-1:0] r);
        return e.we && (e.dst == r) && (r != '0);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
//   Compares one scoreboard entry against one ID-stage source operand.
//
//   entry      in  scoreboard entry {dst, we, tnew}
//   src        in  source register being read in ID
//   tuse       in  stage distance at which the operand is needed
//   hit        out entry writes src (never for $0)
//   ready      out entry's result already exists (tnew == 0)
//   need_stall out entry writes src and its result arrives too late
// -----------------------------------------------------------------------------
module sb_match
    import hazard_scoreboard_pkg::*;
(
    input  sb_entry_t            entry,
    input  logic [SB_REG_AW-1:0] src,
    input  logic [1:0]           tuse,
    output logic                 hit,
    output logic                 ready,
    output logic                 need_stall
);

    assign hit        = entry_hits(entry, src);
    assign ready      = (entry.tnew == 2'd0);
    assign need_stall = hit && (entry.tnew > tuse);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Shadows the destination, RegWrite and Tnew of the instructions in EX, MEM
//   and WB and checks them against the ID-stage source operands. Produces the
//   stall (freeze PC and IF/ID, bubble ID/EX), the ID and EX forwarding
//   selects and a free-running count of stalled cycles.
//
//   clk, reset            clock, asynchronous active-high reset
//   ID_rs/ID_rt           ID source registers
//   ID_useRs/ID_useRt     instruction actually reads rs / rt
//   ID_tuseRs/ID_tuseRt   stage distance at which rs / rt is needed
//   ID_dst, ID_RegWrite   destination and write enable of the ID instruction
//   ID_timeNew            Tnew of the ID instruction, measured at ID
//   stall                 combinational hazard stall
//   ID_fwdRs/ID_fwdRt     0 regfile, 1 EX, 2 MEM, 3 WB
//   EX_fwdRs/EX_fwdRt     0 ID/EX register, 2 MEM, 3 WB
//   stall_cnt             number of cycles with stall asserted (wraps)
// -----------------------------------------------------------------------------
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ID_rs,
    input  logic [REG_AW-1:0] ID_rt,
    input  logic              ID_useRs,
    input  logic              ID_useRt,
    input  logic [1:0]        ID_tuseRs,
    input  logic [1:0]        ID_tuseRt,
    input  logic [REG_AW-1:0] ID_dst,
    input  logic              ID_RegWrite,
    input  logic [1:0]        ID_timeNew,
    output logic              stall,
    output logic [1:0]        ID_fwdRs,
    output logic [1:0]        ID_fwdRt,
    output logic [1:0]        EX_fwdRs,
    output logic [1:0]        EX_fwdRt,
    output logic [CNT_W-1:0]  stall_cnt
);

    // -------------------------------------------------------------------------
    // Scoreboard state
    // -------------------------------------------------------------------------
    sb_entry_t         e_q, m_q, w_q;
    logic [REG_AW-1:0] e_rs_q, e_rt_q;
    logic [CNT_W-1:0]  cnt_q;

    // Entries ordered youngest first so index order is forwarding priority.
    sb_entry_t ent [3];
    assign ent[0] = e_q;
    assign ent[1] = m_q;
    assign ent[2] = w_q;

    // -------------------------------------------------------------------------
    // ID operand comparison: one comparator per entry per operand.
    // Bit index = stage (0 E, 1 M, 2 W).
    // -------------------------------------------------------------------------
    logic [REG_AW-1:0] id_src  [2];
    logic [1:0]        id_tuse [2];
    logic [2:0]        rs_hit, rs_rdy, rs_ns;
    logic [2:0]        rt_hit, rt_rdy, rt_ns;

    assign id_src[0]  = ID_rs;
    assign id_src[1]  = ID_rt;
    assign id_tuse[0] = ID_tuseRs;
    assign id_tuse[1] = ID_tuseRt;

    for (genvar st = 0; st < 3; st++) begin : g_stage
        sb_match u_rs (
            .entry      (ent[st]),
            .src        (id_src[0]),
            .tuse       (id_tuse[0]),
            .hit        (rs_hit[st]),
            .ready      (rs_rdy[st]),
            .need_stall (rs_ns[st])
        );

        sb_match u_rt (
            .entry      (ent[st]),
            .src        (id_src[1]),
            .tuse       (id_tuse[1]),
            .hit        (rt_hit[st]),
            .ready      (rt_rdy[st]),
            .need_stall (rt_ns[st])
        );
    end

    // W always has tnew == 0, so its need_stall bit is constantly low; it is
    // kept in the reduction only so all three stages are treated alike.
    logic stall_rs, stall_rt;
    assign stall_rs = ID_useRs && (|rs_ns);
    assign stall_rt = ID_useRt && (|rt_ns);
    assign stall    = stall_rs || stall_rt;

    // The youngest matching entry wins. If it is not ready yet the operand
    // cannot be forwarded at all: select the regfile and rely on the stall.
    function automatic logic [1:0] id_sel(input logic [2:0] hit,
                                          input logic [2:0] rdy);
        if (hit[0])      return rdy[0] ? FWD_EX  : FWD_RF;
        else if (hit[1]) return rdy[1] ? FWD_MEM : FWD_RF;
        else if (hit[2]) return rdy[2] ? FWD_WB  : FWD_RF;
        else             return FWD_RF;
    endfunction

    assign ID_fwdRs = id_sel(rs_hit, rs_rdy);
    assign ID_fwdRt = id_sel(rt_hit, rt_rdy);

    // -------------------------------------------------------------------------
    // EX operand forwarding, against the operands latched with the E entry.
    // A pending M match shadows W even when it is not ready.
    // -------------------------------------------------------------------------
    function automatic logic [1:0] ex_sel(input sb_entry_t         m,
                                          input sb_entry_t         w,
                                          input logic [REG_AW-1:0] r);
        if (entry_hits(m, r))      return (m.tnew == 2'd0) ? FWD_MEM : FWD_RF;
        else if (entry_hits(w, r)) return FWD_WB;
        else                       return FWD_RF;
    endfunction

    assign EX_fwdRs = ex_sel(m_q, w_q, e_rs_q);
    assign EX_fwdRt = ex_sel(m_q, w_q, e_rt_q);

    assign stall_cnt = cnt_q;

    // -------------------------------------------------------------------------
    // Pipeline advance. A stalled instruction stays in ID, so E takes a
    // bubble and the ID inputs are re-evaluated next cycle.
    // -------------------------------------------------------------------------
    sb_entry_t e_next;

    // NOTE: combinational blocks assign every output first so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        e_next = SB_BUBBLE;
        if (!stall) begin
            e_next.dst  = ID_dst;
            e_next.we   = ID_RegWrite;
            e_next.tnew = tnew_dec(ID_timeNew);
        end
    end

    // NOTE: registered state uses non-blocking assignments so every stage
    // samples the previous value of the stage ahead of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_q    <= SB_BUBBLE;
            m_q    <= SB_BUBBLE;
            w_q    <= SB_BUBBLE;
            e_rs_q <= '0;
            e_rt_q <= '0;
            cnt_q  <= '0;
        end else begin
            e_q      <= e_next;
            e_rs_q   <= stall ? '0 : ID_rs;
            e_rt_q   <= stall ? '0 : ID_rt;
            m_q.dst  <= e_q.dst;
            m_q.we   <= e_q.we;
            m_q.tnew <= tnew_dec(e_q.tnew);
            w_q.dst  <= m_q.dst;
            w_q.we   <= m_q.we;
            w_q.tnew <= tnew_dec(m_q.tnew);
            if (stall) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
